// File: rtl/axi_stream_protocol_checker_pkg.sv
// Shared error indices, vector types and first-error encoding for the AXI4-Stream checker.
package axis_checker_pkg;

    localparam int NUM_ERR = 6;

    localparam int ERR_VALID_DROP    = 0;
    localparam int ERR_PAYLOAD_CHG   = 1;
    localparam int ERR_STRB_NO_KEEP  = 2;
    localparam int ERR_RESET_VALID   = 3;
    localparam int ERR_PKT_TOO_LONG  = 4;
    localparam int ERR_STALL_TIMEOUT = 5;

    typedef logic [NUM_ERR-1:0] err_vec_t;
    typedef logic [2:0]         err_idx_t;

    // Lowest set bit index plus one; zero means no error in the vector.
    function automatic err_idx_t first_err_code(input err_vec_t v);
        first_err_code = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) first_err_code = err_idx_t'(i + 1);
        end
    endfunction

endpackage

// File: rtl/axi_stream_protocol_checker_if.sv
// AXI4-Stream bundle with driver, receiver and passive tap views.
interface axi_stream_protocol_checker_if #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 0,
    parameter int DEST_WIDTH = 0,
    parameter int USER_WIDTH = 0
);
    localparam int ID_W   = (ID_WIDTH   > 0) ? ID_WIDTH   : 1;
    localparam int DEST_W = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;
    localparam int USER_W = (USER_WIDTH > 0) ? USER_WIDTH : 1;

    // A beat transfers on a clock edge where tvalid && tready; once tvalid rises it must hold,
    // with a stable payload, until that transfer. tready may change freely.
    logic                    tvalid;
    logic                    tready;
    logic [8*BYTE_WIDTH-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tstrb;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic                    tlast;
    logic [ID_W-1:0]         tid;
    logic [DEST_W-1:0]       tdest;
    logic [USER_W-1:0]       tuser;

    modport master  (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave   (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
    modport monitor (input tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser);

endinterface

// File: rtl/axi_stream_protocol_checker_popcount.sv
// Counts set TKEEP bits, i.e. the number of valid bytes in one beat.
module axis_keep_popcount #(
    parameter int BYTE_WIDTH = 4,
    parameter int CW         = $clog2(BYTE_WIDTH + 1)
) (
    input  logic [BYTE_WIDTH-1:0] keep,
    output logic [CW-1:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI4-Stream protocol checker: flags handshake/payload/keep/reset/length/stall
// violations and keeps saturating beat, byte and packet statistics.
module axi_stream_protocol_checker
    import axis_checker_pkg::*;
#(
    parameter int BYTE_WIDTH    = 4,
    parameter int ID_WIDTH      = 0,
    parameter int DEST_WIDTH    = 0,
    parameter int USER_WIDTH    = 0,
    parameter int CNT_WIDTH     = 32,
    parameter int MAX_PKT_BEATS = 0,
    parameter int STALL_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_stream_protocol_checker_if.monitor axis,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic [CNT_WIDTH-1:0] byte_cnt,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output err_vec_t             err_pulse,
    output err_vec_t             err_sticky,
    output err_idx_t             err_first
);

    localparam int KCW = $clog2(BYTE_WIDTH + 1);

    logic xfer, stall;
    logic first_cyc, prev_stall;
    logic [8*BYTE_WIDTH-1:0] data_q;
    logic [BYTE_WIDTH-1:0]   strb_q, keep_q;
    logic                    last_q;
    logic id_chg, dest_chg, user_chg, payload_chg;
    logic det_pkt, det_stall;
    err_vec_t det;
    logic [KCW-1:0] keep_pop;

    assign xfer  = axis.tvalid && axis.tready;
    assign stall = axis.tvalid && !axis.tready;

    axis_keep_popcount #(.BYTE_WIDTH(BYTE_WIDTH), .CW(KCW)) u_pop (
        .keep  (axis.tkeep),
        .count (keep_pop)
    );

    // Payload copy refreshes on every valid cycle, so during a stall it holds last cycle's beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_cyc  <= 1'b1;
            prev_stall <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            first_cyc  <= 1'b0;
            prev_stall <= stall;
            if (axis.tvalid) begin
                data_q <= axis.tdata;
                strb_q <= axis.tstrb;
                keep_q <= axis.tkeep;
                last_q <= axis.tlast;
            end
        end
    end

    if (ID_WIDTH > 0) begin : g_id
        logic [ID_WIDTH-1:0] id_q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)          id_q <= '0;
            else if (axis.tvalid) id_q <= axis.tid;
        end
        assign id_chg = (axis.tid != id_q);
    end else begin : g_no_id
        assign id_chg = 1'b0 & (^axis.tid);
    end

    if (DEST_WIDTH > 0) begin : g_dest
        logic [DEST_WIDTH-1:0] dest_q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)          dest_q <= '0;
            else if (axis.tvalid) dest_q <= axis.tdest;
        end
        assign dest_chg = (axis.tdest != dest_q);
    end else begin : g_no_dest
        assign dest_chg = 1'b0 & (^axis.tdest);
    end

    if (USER_WIDTH > 0) begin : g_user
        logic [USER_WIDTH-1:0] user_q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)          user_q <= '0;
            else if (axis.tvalid) user_q <= axis.tuser;
        end
        assign user_chg = (axis.tuser != user_q);
    end else begin : g_no_user
        assign user_chg = 1'b0 & (^axis.tuser);
    end

    assign payload_chg = (axis.tdata != data_q) || (axis.tstrb != strb_q) ||
                         (axis.tkeep != keep_q) || (axis.tlast != last_q) ||
                         id_chg || dest_chg || user_chg;

    // Beat position within the packet; once over-length it freezes until the closing tlast.
    if (MAX_PKT_BEATS > 0) begin : g_pkt_len
        localparam int PCW = $clog2(MAX_PKT_BEATS + 1);
        logic [PCW-1:0] pkt_beats;
        logic           pkt_over;
        assign det_pkt = xfer && !axis.tlast && !pkt_over &&
                         (pkt_beats == PCW'(MAX_PKT_BEATS - 1));
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                pkt_beats <= '0;
                pkt_over  <= 1'b0;
            end else if (xfer) begin
                if (axis.tlast) begin
                    pkt_beats <= '0;
                    pkt_over  <= 1'b0;
                end else if (det_pkt) begin
                    pkt_over  <= 1'b1;
                end else if (!pkt_over) begin
                    pkt_beats <= pkt_beats + PCW'(1);
                end
            end
        end
    end else begin : g_no_pkt_len
        assign det_pkt = 1'b0;
    end

    // Saturating at the limit means the equality below is true only once per stall episode.
    if (STALL_TIMEOUT > 0) begin : g_stall
        localparam int SCW = $clog2(STALL_TIMEOUT + 1);
        logic [SCW-1:0] stall_cnt;
        assign det_stall = stall && (stall_cnt == SCW'(STALL_TIMEOUT - 1));
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                stall_cnt <= '0;
            end else if (stall) begin
                if (stall_cnt != SCW'(STALL_TIMEOUT)) stall_cnt <= stall_cnt + SCW'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end else begin : g_no_stall
        assign det_stall = 1'b0;
    end

    always_comb begin
        det                    = '0;
        det[ERR_VALID_DROP]    = prev_stall && !axis.tvalid;
        det[ERR_PAYLOAD_CHG]   = prev_stall && axis.tvalid && payload_chg;
        det[ERR_STRB_NO_KEEP]  = axis.tvalid && |(axis.tstrb & ~axis.tkeep);
        det[ERR_RESET_VALID]   = first_cyc && axis.tvalid;
        det[ERR_PKT_TOO_LONG]  = det_pkt;
        det[ERR_STALL_TIMEOUT] = det_stall;
    end

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH:0]   b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + b;
        sat_add = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // A detection in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_pulse  <= '0;
            err_sticky <= '0;
            err_first  <= '0;
            beat_cnt   <= '0;
            byte_cnt   <= '0;
            pkt_cnt    <= '0;
        end else begin
            err_pulse  <= det;
            err_sticky <= (clear ? '0 : err_sticky) | det;
            if (clear || (err_first == '0)) err_first <= first_err_code(det);
            if (clear) begin
                beat_cnt <= '0;
                byte_cnt <= '0;
                pkt_cnt  <= '0;
            end else if (xfer) begin
                beat_cnt <= sat_add(beat_cnt, (CNT_WIDTH+1)'(1));
                byte_cnt <= sat_add(byte_cnt, (CNT_WIDTH+1)'(keep_pop));
                if (axis.tlast) pkt_cnt <= sat_add(pkt_cnt, (CNT_WIDTH+1)'(1));
            end
        end
    end

endmodule
